minv_result_reader: RTL and testbench

- Read-side counterpart of the modular inversion/division datapath, which is loaded 32 bits per cycle through its datain path.
- Watches the ready flag and, on its rising edge, snapshots the 256-bit result `u` and the no-inverse flag.
- Streams the result out as eight 32-bit words, least-significant word first, over a valid/ready handshake to the bus-side host interface.

---
 rtl/minv_result_if.sv | 27 ++
 rtl/minv_result_reader.sv | 116 +++++++++++
 tb/tb_minv_result_reader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/minv_result_if.sv
// Valid/ready word stream carrying the snapshotted inversion result to the host side.
// A word transfers on a rising clock edge where valid & ready are both 1. Once raised, valid stays up with data/last/err stable until that transfer.
interface minv_result_if #(
  parameter int DW = 32
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;
  logic          err;

  modport master (
    output valid,
    output data,
    output last,
    output err,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    input  err,
    output ready
  );
endinterface

// File: rtl/minv_result_reader.sv
// Captures the 256-bit modular-inversion result on a rise of minv_rdy.
// It then streams the result LSW first as WORDS words over a valid/ready interface.
module minv_result_reader #(
  parameter int DW    = 32,
  parameter int WORDS = 8,
  parameter int CW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                minv_rdy,
  input  logic                minv_flag,
  input  logic [DW*WORDS-1:0] u,
  minv_result_if.master       dout,
  output logic                done,
  output logic                busy,
  output logic                ovr,
  input  logic                ovr_clr,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                rdy_d;
  logic                rise;
  logic [DW*WORDS-1:0] shadow;
  logic [CW-1:0]       cnt;
  logic                err_q;
  logic                ovr_q;
  logic                xfer;
  logic                last_word;

  assign rise      = minv_rdy & ~rdy_d;
  assign last_word = (cnt == CW'(WORDS - 1));
  assign xfer      = (state == S_SEND) & dout.ready;
  assign state_dbg = state;
  assign ovr       = ovr_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (rise) state_nx = S_SEND;
      S_SEND: if (xfer && last_word) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Snapshot, word counter and overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_d  <= 1'b0;
      shadow <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      rdy_d <= minv_rdy;
      if (state == S_IDLE && rise) begin
        shadow <= u;
        err_q  <= minv_flag;
        cnt    <= '0;
      end else if (xfer) begin
        shadow <= shadow >> DW;
        // Hold on the final word so the counter never wraps mid-burst.
        if (!last_word) cnt <= cnt + CW'(1);
      end
      // A rise that cannot be captured sets ovr and outranks a same-cycle clear.
      if (rise && state != S_IDLE) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  // Output decode
  always_comb begin
    dout.valid = 1'b0;
    dout.data  = '0;
    dout.last  = 1'b0;
    dout.err   = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    case (state)
      S_SEND: begin
        dout.valid = 1'b1;
        dout.data  = shadow[DW-1:0];
        dout.last  = last_word;
        dout.err   = err_q;
        busy       = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_minv_result_reader.sv
// Bench for minv_result_reader: directed scenarios plus random traffic.
// Responses are checked against a word-queue reference model.
module tb_minv_result_reader;

  localparam int DW    = 32;
  localparam int WORDS = 8;

  logic                clk;
  logic                rst;
  logic                minv_rdy;
  logic                minv_flag;
  logic [DW*WORDS-1:0] u;
  logic                done;
  logic                busy;
  logic                ovr;
  logic                ovr_clr;
  logic [1:0]          state_dbg;

  minv_result_if #(.DW(DW)) dout_if ();

  minv_result_reader #(.DW(DW), .WORDS(WORDS), .CW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .minv_rdy  (minv_rdy),
    .minv_flag (minv_flag),
    .u         (u),
    .dout      (dout_if),
    .done      (done),
    .busy      (busy),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr),
    .state_dbg (state_dbg)
  );

  // Clock and safety timeout
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a captured result becomes WORDS queued words {last, err, data}.
  logic [DW+1:0] exp_q[$];
  logic          m_prev;
  int            m_left;
  logic          m_done;
  logic          m_ovr;
  logic          m_rise;
  logic          m_busy;
  logic          m_xfer;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev = 1'b0;
      m_left = 0;
      m_done = 1'b0;
      m_ovr  = 1'b0;
      exp_q.delete();
    end else begin
      m_rise = minv_rdy && !m_prev;
      m_prev = minv_rdy;
      m_busy = (m_left > 0) || m_done;
      m_xfer = (m_left > 0) && dout_if.ready;
      m_done = m_xfer && (m_left == 1);
      if (m_xfer) m_left--;
      if (m_rise && m_busy) m_ovr = 1'b1;
      else if (ovr_clr)     m_ovr = 1'b0;
      if (m_rise && !m_busy) begin
        for (int i = 0; i < WORDS; i++)
          exp_q.push_back({(i == WORDS - 1), minv_flag, u[DW*i +: DW]});
        m_left = WORDS;
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("valid", 64'(dout_if.valid), 64'(m_left > 0));
      check("busy",  64'(busy),  64'((m_left > 0) || m_done));
      check("done",  64'(done),  64'(m_done));
      check("ovr",   64'(ovr),   64'(m_ovr));
      if (done) done_cnt++;
      if (dout_if.valid) begin
        if (exp_q.size() == 0) begin
          check("word_unexpected", 64'({dout_if.last, dout_if.err, dout_if.data}), 64'hdead_0000_0000);
        end else begin
          check("word", 64'({dout_if.last, dout_if.err, dout_if.data}), 64'(exp_q[0]));
          if (dout_if.ready) void'(exp_q.pop_front());
        end
      end else begin
        check("err_idle", 64'(dout_if.err), 64'd0);
      end
    end
  end

  // Driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (((m_left > 0) || m_done) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("idle_timeout", 64'd1, 64'd0);
    step(2);
  endtask

  task automatic start_burst(input logic [DW*WORDS-1:0] val, input logic flag);
    u         = val;
    minv_flag = flag;
    minv_rdy  = 1'b1;
    step();
    minv_rdy  = 1'b0;
  endtask

  function automatic logic [DW*WORDS-1:0] counting_u();
    logic [DW*WORDS-1:0] v;
    for (int i = 0; i < WORDS; i++) v[DW*i +: DW] = DW'(i + 1);
    return v;
  endfunction

  function automatic logic [DW*WORDS-1:0] random_u();
    logic [DW*WORDS-1:0] v;
    for (int i = 0; i < WORDS; i++) v[DW*i +: DW] = $urandom();
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(dout_if.valid), 64'd0);
    check({tag, "_busy"},  64'(busy),          64'd0);
    check({tag, "_done"},  64'(done),          64'd0);
    check({tag, "_ovr"},   64'(ovr),           64'd0);
    check({tag, "_data"},  64'(dout_if.data),  64'd0);
    check({tag, "_last"},  64'(dout_if.last),  64'd0);
    check({tag, "_err"},   64'(dout_if.err),   64'd0);
  endtask

  int d0;

  // Stimulus
  initial begin
    rst           = 1'b1;
    minv_rdy      = 1'b0;
    minv_flag     = 1'b0;
    u             = '0;
    ovr_clr       = 1'b0;
    dout_if.ready = 1'b0;
    #23;
    check_all_zero("reset");
    step();
    rst = 1'b0;
    step(2);

    // Basic burst
    dout_if.ready = 1'b1;
    d0 = done_cnt;
    start_burst(counting_u(), 1'b0);
    wait_idle(40);
    check("basic_done_count", 64'(done_cnt - d0), 64'd1);

    // Backpressure with ready pattern 1,0,0
    d0 = done_cnt;
    start_burst(counting_u(), 1'b0);
    for (int k = 0; k < 60 && ((m_left > 0) || m_done); k++) begin
      dout_if.ready = (k % 3 == 0);
      step();
    end
    dout_if.ready = 1'b1;
    wait_idle(40);
    check("bp_done_count", 64'(done_cnt - d0), 64'd1);

    // No-inverse flag
    start_burst(256'h5, 1'b1);
    minv_flag = 1'b0;
    wait_idle(40);

    // Overrun during word 3, inputs changed after capture
    start_burst(counting_u(), 1'b0);
    step(2);
    u         = random_u();
    minv_flag = 1'b1;
    minv_rdy  = 1'b1;
    step();
    minv_rdy  = 1'b0;
    check("ovr_set", 64'(ovr), 64'd1);
    wait_idle(40);
    step(3);
    check("ovr_sticky", 64'(ovr), 64'd1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_cleared", 64'(ovr), 64'd0);

    // ovr_clr coincident with a busy rise: set wins
    start_burst(random_u(), 1'b0);
    step(2);
    minv_rdy = 1'b1;
    ovr_clr  = 1'b1;
    step();
    minv_rdy = 1'b0;
    ovr_clr  = 1'b0;
    check("ovr_set_wins", 64'(ovr), 64'd1);
    wait_idle(40);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;

    // Level hold: one burst only
    d0 = done_cnt;
    u = random_u();
    minv_rdy = 1'b1;
    step(40);
    minv_rdy = 1'b0;
    wait_idle(40);
    check("hold_done_count", 64'(done_cnt - d0), 64'd1);

    // Reset mid-burst, during word 5
    start_burst(counting_u(), 1'b0);
    step(4);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    step();
    rst = 1'b0;
    step(2);
    d0 = done_cnt;
    start_burst(random_u(), 1'b1);
    wait_idle(40);
    check("post_rst_done_count", 64'(done_cnt - d0), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      dout_if.ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) minv_rdy = ~minv_rdy;
      ovr_clr   = ($urandom_range(0, 19) == 0);
      minv_flag = $urandom_range(0, 1);
      u         = random_u();
      step();
    end
    minv_rdy      = 1'b0;
    ovr_clr       = 1'b0;
    dout_if.ready = 1'b1;
    wait_idle(100);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
